// File: rtl/rc4_ctrl.sv
// RC4 sequencing controller: S-box init, key scheduling and keystream generation
// around an external 256x8 S-box RAM. Define RC4_DROP_EN to discard the first DROP_N bytes.
module rc4_ctrl #(
  parameter int DROP_N = 768
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] key_len,
  output logic [7:0] key_idx,
  input  logic [7:0] key_byte,
  output logic [7:0] ram_raddr1,
  input  logic [7:0] ram_rdata1,
  output logic       ram_wen2,
  output logic [7:0] ram_waddr2,
  output logic [7:0] ram_wdata2,
  output logic       ram_wen3,
  output logic [7:0] ram_addr3,
  output logic [7:0] ram_wdata3,
  input  logic [7:0] ram_rdata3,
  output logic       busy,
  output logic       key_ready,
  output logic       ks_valid,
  input  logic       ks_ready,
  output logic [7:0] ks_data
);

  typedef enum logic [3:0] {
    IDLE, INIT, KSA_RD, KSA_J, KSA_RJ, KSA_SW,
    P_RI, P_J, P_RJ, P_SW, P_RK, P_LD, P_OUT
  } state_t;

  state_t     state, state_nx;
  logic [7:0] i, j, k, si, kidx;
  logic       abort;
  logic       drop_byte;

`ifdef RC4_DROP_EN
  logic [31:0] drop_cnt;
  assign drop_byte = (drop_cnt < 32'(DROP_N));
`else
  // Keeps the parameter referenced in builds without the drop stage.
  logic unused_drop_n;
  assign unused_drop_n = ^DROP_N;
  assign drop_byte     = 1'b0;
`endif

  assign abort   = !rst_n || (stop && state != IDLE);
  assign busy    = (state != IDLE);
  assign key_idx = kidx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    state_nx   = state;
    ram_raddr1 = '0;
    ram_wen2   = 1'b0;
    ram_waddr2 = '0;
    ram_wdata2 = '0;
    ram_wen3   = 1'b0;
    ram_addr3  = '0;
    ram_wdata3 = '0;
    case (state)
      IDLE:   if (start) state_nx = INIT;
      INIT: begin
        ram_wen2   = 1'b1;
        ram_waddr2 = i;
        ram_wdata2 = i;
        if (i == 8'hff) state_nx = KSA_RD;
      end
      KSA_RD: begin
        ram_raddr1 = i;
        state_nx   = KSA_J;
      end
      KSA_J:  state_nx = KSA_RJ;
      KSA_RJ: begin
        ram_addr3 = j;
        state_nx  = KSA_SW;
      end
      KSA_SW, P_SW: begin
        // When i == j both ports write the same value to the same address.
        ram_wen2   = 1'b1;
        ram_waddr2 = i;
        ram_wdata2 = ram_rdata3;
        ram_wen3   = 1'b1;
        ram_addr3  = j;
        ram_wdata3 = si;
        if (state == P_SW)    state_nx = P_RK;
        else if (i == 8'hff)  state_nx = P_RI;
        else                  state_nx = KSA_RD;
      end
      P_RI: begin
        ram_raddr1 = i + 8'd1;
        state_nx   = P_J;
      end
      P_J:  state_nx = P_RJ;
      P_RJ: begin
        ram_addr3 = j;
        state_nx  = P_SW;
      end
      P_RK: begin
        ram_raddr1 = k;
        state_nx   = P_LD;
      end
      P_LD:   state_nx = drop_byte ? P_RI : P_OUT;
      P_OUT:  if (ks_ready) state_nx = P_RI;
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      ram_wen2 = 1'b0;
      ram_wen3 = 1'b0;
      if (state != IDLE) state_nx = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      kidx      <= '0;
      key_ready <= 1'b0;
      ks_valid  <= 1'b0;
      ks_data   <= '0;
`ifdef RC4_DROP_EN
      drop_cnt  <= '0;
`endif
    end else if (stop && state != IDLE) begin
      ks_valid  <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          i         <= '0;
          j         <= '0;
          kidx      <= '0;
          key_ready <= 1'b0;
`ifdef RC4_DROP_EN
          drop_cnt  <= '0;
`endif
        end
        INIT: i <= i + 8'd1;
        KSA_J: begin
          si   <= ram_rdata1;
          j    <= j + ram_rdata1 + key_byte;
          // key_len of 0 wraps after 255 through the same mod-256 compare.
          kidx <= (kidx == key_len - 8'd1) ? 8'd0 : kidx + 8'd1;
        end
        KSA_SW: begin
          i <= i + 8'd1;
          if (i == 8'hff) begin
            j         <= '0;
            key_ready <= 1'b1;
          end
        end
        P_RI: i <= i + 8'd1;
        P_J: begin
          si <= ram_rdata1;
          j  <= j + ram_rdata1;
        end
        P_SW: k <= si + ram_rdata3;
        P_LD: begin
          ks_data <= ram_rdata1;
`ifdef RC4_DROP_EN
          if (drop_byte) drop_cnt <= drop_cnt + 32'd1;
          else           ks_valid <= 1'b1;
`else
          ks_valid <= 1'b1;
`endif
        end
        P_OUT: if (ks_ready) ks_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
